tff_bank_sequencer: RTL

Controller that drives a WIDTH-bit bank of T flip-flops as a programmable counter/loader.
- Each cycle it computes the per-bit toggle vector t = q ^ q_next, so the bank itself only ever toggles.
- A start/done handshake frames each operation: count up to a limit, count down to a limit, or parallel load.
- Sits between a host controller and the toggle-flop storage.

---
 rtl/tff_seq_pkg.sv | 24 ++
 rtl/tff_cell.sv | 24 ++
 rtl/tff_bank_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/tff_seq_pkg.sv
// Shared encodings for the toggle-flop bank sequencer.
// State and mode codes used by the sequencer and its bench.
package tff_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b10;
  localparam logic [1:0] MODE_NOP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  function automatic logic needs_run(input logic [1:0] m);
    return m != MODE_NOP;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles on posedge clk when t is high.
// Async active-low reset clears q (q_inverse reads back as 1).
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q,
  output logic q_inverse
);

  logic q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else if (t) begin
      q_q <= ~q_q;
    end
  end

  assign q         = q_q;
  assign q_inverse = ~q_q;

endmodule

// File: rtl/tff_bank_sequencer.sv
// Counter/loader that drives a bank of T flip-flops via a toggle vector.
// Optional abort input/aborted output under TFF_SEQ_ABORT_EN.
module tff_bank_sequencer
  import tff_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
`ifdef TFF_SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_inverse,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] limit_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] t_d;
  logic [WIDTH-1:0] step_d;
  logic             run_end_d;
  logic             abort_hit;

`ifdef TFF_SEQ_ABORT_EN
  logic aborted_q;
  assign abort_hit = abort && (state_q == S_RUN);
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  // Abort beats load, load beats the terminal check.
  always_comb begin
    t_d       = '0;
    run_end_d = 1'b0;
    step_d    = (mode_q == MODE_DOWN) ? q - ONE : q + ONE;
    if (state_q == S_RUN) begin
      if (abort_hit) begin
        run_end_d = 1'b1;
      end else if (mode_q == MODE_LOAD) begin
        t_d       = q ^ load_q;
        run_end_d = 1'b1;
      end else if (q == limit_q) begin
        run_end_d = 1'b1;
      end else begin
        t_d = q ^ step_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      load_q    <= '0;
      limit_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef TFF_SEQ_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mode_q  <= mode;
            load_q  <= load_val;
            limit_q <= limit;
            if (needs_run(mode)) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (run_end_d) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
`ifdef TFF_SEQ_ABORT_EN
            aborted_q <= abort_hit;
`endif
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          done_q    <= 1'b0;
`ifdef TFF_SEQ_ABORT_EN
          aborted_q <= 1'b0;
`endif
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    tff_cell u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .t         (t_d[i]),
      .q         (q[i]),
      .q_inverse (q_inverse[i])
    );
  end

  assign t_vec = t_d;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
